// File: rtl/ex_lsu.sv
// ex_lsu: EX-stage load/store unit running a req/gnt/rvalid data-memory transaction.
// Define LSU_MISALIGN_TRAP_EN to trap misaligned H/W accesses instead of issuing them.
module ex_lsu #(
  parameter int unsigned GNT_TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] op1_i,
  input  logic [31:0] op2_i,
  input  logic [31:0] mem_data_i,
  input  logic [2:0]  mem_size_i,
  input  logic        mem_we_i,
  input  logic        mem_re_i,
  input  logic [4:0]  rd_addr_i,
  input  logic        reg_wen_i,
  output logic        dm_req_o,
  output logic        dm_we_o,
  output logic [31:0] dm_addr_o,
  output logic [3:0]  dm_be_o,
  output logic [31:0] dm_wdata_o,
  input  logic        dm_gnt_i,
  input  logic        dm_rvalid_i,
  input  logic [31:0] dm_rdata_i,
  output logic        hold_flag_o,
  output logic        wb_valid_o,
  output logic [4:0]  wb_rd_o,
  output logic [31:0] wb_data_o,
  output logic        bus_err_o,
  output logic        misalign_o
);
  typedef enum logic [1:0] {IDLE, REQ, RESP, DONE} state_t;
`ifdef LSU_MISALIGN_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif
  state_t      state;
  logic [31:0] ea, cnt, cnt_nxt, wdata, ld_data;
  logic [3:0]  be;
  logic [2:0]  size;
  logic [1:0]  ea_lo;
  logic [4:0]  rd;
  logic [7:0]  lb;
  logic [15:0] lh;
  logic        is_b, is_h, start, mis, tmo, we, rd_wen;
  assign ea      = op1_i + op2_i;
  assign is_b    = mem_size_i[1:0] == 2'b00;
  assign is_h    = mem_size_i[1:0] == 2'b01;
  assign start   = mem_re_i | mem_we_i;
  assign mis     = TRAP && ((is_h && ea[0]) || (!is_b && !is_h && ea[1:0] != 2'b00));
  assign hold_flag_o = (state == IDLE) ? start : (state != DONE);
  assign cnt_nxt = cnt + 32'd1;
  assign tmo     = (GNT_TIMEOUT != 0) && (cnt_nxt == GNT_TIMEOUT);
  // Sizes 011 and 11x fall through to word handling.
  assign be      = is_b ? 4'b0001 << ea[1:0] : is_h ? (ea[1] ? 4'b1100 : 4'b0011) : 4'b1111;
  assign wdata   = is_b ? {4{mem_data_i[7:0]}} : is_h ? {2{mem_data_i[15:0]}} : mem_data_i;
  assign lb      = dm_rdata_i[{ea_lo, 3'b000} +: 8];
  assign lh      = dm_rdata_i[{ea_lo[1], 4'b0000} +: 16];
  assign ld_data = size[1:0] == 2'b00 ? {{24{lb[7] & ~size[2]}}, lb}
                 : size[1:0] == 2'b01 ? {{16{lh[15] & ~size[2]}}, lh}
                 : dm_rdata_i;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      cnt        <= '0;
      dm_req_o   <= 1'b0;
      dm_we_o    <= 1'b0;
      dm_addr_o  <= '0;
      dm_be_o    <= '0;
      dm_wdata_o <= '0;
      wb_valid_o <= 1'b0;
      wb_rd_o    <= '0;
      wb_data_o  <= '0;
      bus_err_o  <= 1'b0;
      misalign_o <= 1'b0;
      we         <= 1'b0;
      rd         <= '0;
      rd_wen     <= 1'b0;
      size       <= '0;
      ea_lo      <= '0;
    end else begin
      wb_valid_o <= 1'b0;
      bus_err_o  <= 1'b0;
      misalign_o <= 1'b0;
      cnt        <= cnt_nxt;
      case (state)
        IDLE: if (start) begin
          dm_addr_o  <= {ea[31:2], 2'b00};
          dm_be_o    <= be;
          dm_wdata_o <= wdata;
          dm_we_o    <= mem_we_i;
          we         <= mem_we_i;
          rd         <= rd_addr_i;
          rd_wen     <= reg_wen_i;
          size       <= mem_size_i;
          ea_lo      <= ea[1:0];
          cnt        <= '0;
          dm_req_o   <= !mis;
          misalign_o <= mis;
          state      <= mis ? DONE : REQ;
        end
        REQ: if (dm_gnt_i || tmo) begin
          dm_req_o  <= 1'b0;
          cnt       <= '0;
          bus_err_o <= !dm_gnt_i;
          state     <= (dm_gnt_i && !we) ? RESP : DONE;
        end
        RESP: if (dm_rvalid_i || tmo) begin
          wb_valid_o <= dm_rvalid_i && rd_wen;
          wb_rd_o    <= rd;
          wb_data_o  <= ld_data;
          bus_err_o  <= !dm_rvalid_i;
          state      <= DONE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_ex_lsu.sv
// tb_ex_lsu: directed bench for ex_lsu; a per-cycle protocol model drives expectations
// that a single negedge compare process checks, plus literal checks on captured results.
module tb_ex_lsu;
  localparam int TO = 4;
`ifdef LSU_MISALIGN_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif
  logic        clk = 1'b0, rst = 1'b0;
  logic [31:0] op1, op2, mem_data, dm_addr, dm_wdata, dm_rdata, wb_data;
  logic [2:0]  mem_size;
  logic [4:0]  rd_addr, wb_rd;
  logic [3:0]  dm_be;
  logic        mem_we, mem_re, reg_wen, dm_req, dm_we, dm_gnt, dm_rvalid;
  logic        hold, wb_valid, bus_err, misalign;
  int          checks = 0, errors = 0;
  logic        e_req, e_hold, e_wbv, e_err, e_mis, e_we;
  logic [31:0] e_addr, e_wdata, e_wbd;
  logic [3:0]  e_be;
  logic [4:0]  e_rd;
  logic [31:0] c_addr, c_wdata, c_wbd;
  logic [3:0]  c_be;
  logic [4:0]  c_rd;
  logic        c_we;
  int          hold_cyc, req_cyc, wbv_cyc, err_cyc, mis_cyc, cyc;

  always #5 clk = ~clk;

  ex_lsu #(.GNT_TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .op1_i(op1), .op2_i(op2), .mem_data_i(mem_data),
    .mem_size_i(mem_size), .mem_we_i(mem_we), .mem_re_i(mem_re), .rd_addr_i(rd_addr),
    .reg_wen_i(reg_wen), .dm_req_o(dm_req), .dm_we_o(dm_we), .dm_addr_o(dm_addr),
    .dm_be_o(dm_be), .dm_wdata_o(dm_wdata), .dm_gnt_i(dm_gnt), .dm_rvalid_i(dm_rvalid),
    .dm_rdata_i(dm_rdata), .hold_flag_o(hold), .wb_valid_o(wb_valid), .wb_rd_o(wb_rd),
    .wb_data_o(wb_data), .bus_err_o(bus_err), .misalign_o(misalign)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int nbytes(input logic [2:0] sz);
    return (sz[1:0] == 2'b00) ? 1 : (sz[1:0] == 2'b01) ? 2 : 4;
  endfunction

  // Lane offset of the access; halves use only the half-word index.
  function automatic int lane(input logic [2:0] sz, input logic [31:0] ea);
    int n = nbytes(sz);
    return (n == 4) ? 0 : (n == 2) ? int'(ea % 32'd4) / 2 * 2 : int'(ea % 32'd4);
  endfunction

  function automatic logic [3:0] m_be(input logic [2:0] sz, input logic [31:0] ea);
    logic [3:0] v = '0;
    for (int i = 0; i < nbytes(sz); i++) v[lane(sz, ea) + i] = 1'b1;
    return v;
  endfunction

  function automatic logic [31:0] m_wdata(input logic [2:0] sz, input logic [31:0] d);
    logic [31:0] v;
    for (int i = 0; i < 4; i++) v[8*i +: 8] = d[8*(i % nbytes(sz)) +: 8];
    return v;
  endfunction

  function automatic logic [31:0] m_load(input logic [2:0] sz, input logic [31:0] ea, input logic [31:0] rdata);
    int n = nbytes(sz);
    logic [31:0] v, mask;
    v = rdata >> (8 * lane(sz, ea));
    if (n < 4) begin
      mask = (32'd1 << (8 * n)) - 32'd1;
      v = v & mask;
      if (!sz[2] && v[8*n-1]) v = v | ~mask;
    end
    return v;
  endfunction

  function automatic logic m_mis(input logic [2:0] sz, input logic [31:0] ea);
    return TRAP && ((nbytes(sz) == 2 && ea % 2 != 0) || (nbytes(sz) == 4 && ea % 4 != 0));
  endfunction

  always @(negedge clk) begin
    chk("hold", hold, e_hold);
    chk("req", dm_req, e_req);
    chk("wb_valid", wb_valid, e_wbv);
    chk("bus_err", bus_err, e_err);
    chk("misalign", misalign, e_mis);
    if (e_req) begin
      chk("addr", dm_addr, e_addr);
      chk("be", dm_be, e_be);
      chk("we", dm_we, e_we);
      if (e_we) chk("wdata", dm_wdata, e_wdata);
    end
    if (e_wbv) begin
      chk("wb_rd", wb_rd, e_rd);
      chk("wb_data", wb_data, e_wbd);
    end
    if (dm_req) begin c_addr = dm_addr; c_be = dm_be; c_wdata = dm_wdata; c_we = dm_we; end
    if (wb_valid) begin c_wbd = wb_data; c_rd = wb_rd; end
    hold_cyc += int'(hold);
    req_cyc  += int'(dm_req);
    wbv_cyc  += int'(wb_valid);
    err_cyc  += int'(bus_err);
    mis_cyc  += int'(misalign);
  end

  // One ID/EX op held until its DONE cycle; gdly/rdly < 0 means the slave never answers.
  task automatic run_op(input logic we, input logic re, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] d, input logic [2:0] sz, input logic [4:0] rd, input logic wen,
                        input int gdly, input int rdly, input logic [31:0] rdata);
    logic [31:0] ea = a + b;
    logic ok = 1'b0;
    op1 = a; op2 = b; mem_data = d; mem_size = sz; mem_we = we; mem_re = re;
    rd_addr = rd; reg_wen = wen;
    hold_cyc = 0; req_cyc = 0; wbv_cyc = 0; err_cyc = 0; mis_cyc = 0; cyc = 0;
    c_addr = '0; c_be = '0; c_wdata = '0; c_wbd = '0; c_rd = '0; c_we = 1'b0;
    e_hold = 1'b1; e_req = 1'b0; e_wbv = 1'b0; e_err = 1'b0; e_mis = 1'b0;
    e_addr = {ea[31:2], 2'b00}; e_be = m_be(sz, ea); e_wdata = m_wdata(sz, d); e_we = we;
    @(posedge clk); #1 cyc++;
    if (m_mis(sz, ea)) begin
      e_hold = 1'b0; e_mis = 1'b1;
    end else begin
      e_req = 1'b1;
      for (int i = 0; i < TO && !ok; i++) begin
        dm_gnt = (i == gdly);
        @(posedge clk); #1 cyc++;
        ok = (i == gdly);
      end
      dm_gnt = 1'b0; e_req = 1'b0;
      if (ok && !we) begin
        ok = 1'b0;
        for (int j = 0; j < TO && !ok; j++) begin
          dm_rvalid = (j == rdly); dm_rdata = rdata;
          @(posedge clk); #1 cyc++;
          ok = (j == rdly);
        end
        dm_rvalid = 1'b0;
      end
      e_hold = 1'b0; e_err = !ok; e_wbv = ok && !we && wen; e_rd = rd; e_wbd = m_load(sz, ea, rdata);
    end
    @(posedge clk); #1 cyc++;
    mem_we = 1'b0; mem_re = 1'b0;
    e_wbv = 1'b0; e_err = 1'b0; e_mis = 1'b0;
    @(posedge clk); #1;
  endtask

  initial begin
    op1 = '0; op2 = '0; mem_data = '0; mem_size = '0; mem_we = 1'b0; mem_re = 1'b0;
    rd_addr = '0; reg_wen = 1'b0; dm_gnt = 1'b0; dm_rvalid = 1'b0; dm_rdata = '0;
    e_req = 1'b0; e_hold = 1'b0; e_wbv = 1'b0; e_err = 1'b0; e_mis = 1'b0; e_we = 1'b0;
    e_addr = '0; e_wdata = '0; e_wbd = '0; e_be = '0; e_rd = '0;
    hold_cyc = 0; req_cyc = 0; wbv_cyc = 0; err_cyc = 0; mis_cyc = 0; cyc = 0;
    repeat (2) @(posedge clk);
    #2;
    chk("rst_addr", dm_addr, 32'h0);
    chk("rst_be", dm_be, 4'h0);
    chk("rst_wdata", dm_wdata, 32'h0);
    chk("rst_we", dm_we, 1'b0);
    chk("rst_wb_data", wb_data, 32'h0);
    chk("rst_wb_rd", wb_rd, 5'd0);
    rst = 1'b1;
    @(posedge clk); #1;
    run_op(1'b1, 1'b0, 32'h1000, 32'd4, 32'hDEADBEEF, 3'b010, 5'd0, 1'b0, 0, 0, 32'h0);
    chk("sw_addr", c_addr, 32'h1004);
    chk("sw_be", c_be, 4'b1111);
    chk("sw_wdata", c_wdata, 32'hDEADBEEF);
    chk("sw_hold_cycles", hold_cyc, 2);
    chk("sw_cycles", cyc, 3);
    chk("sw_wbv", wbv_cyc, 0);
    run_op(1'b1, 1'b0, 32'h2000, 32'd3, 32'h000000A5, 3'b000, 5'd0, 1'b0, 0, 0, 32'h0);
    chk("sb_addr", c_addr, 32'h2000);
    chk("sb_be", c_be, 4'b1000);
    chk("sb_wdata", c_wdata, 32'hA5A5A5A5);
    run_op(1'b0, 1'b1, 32'h3000, 32'd1, 32'h0, 3'b000, 5'd5, 1'b1, 0, 0, 32'h00008000);
    chk("lb_data", c_wbd, 32'hFFFFFF80);
    chk("lb_rd", c_rd, 5'd5);
    chk("lb_wbv_pulse", wbv_cyc, 1);
    chk("lb_cycles", cyc, 4);
    run_op(1'b0, 1'b1, 32'h3000, 32'd1, 32'h0, 3'b100, 5'd5, 1'b1, 0, 0, 32'h00008000);
    chk("lbu_data", c_wbd, 32'h00000080);
    run_op(1'b0, 1'b1, 32'h3000, 32'd2, 32'h0, 3'b101, 5'd9, 1'b1, 3, 0, 32'hBEEF1234);
    chk("lhu_data", c_wbd, 32'h0000BEEF);
    chk("lhu_cycles", cyc, 7);
    chk("lhu_hold_cycles", hold_cyc, 6);
    run_op(1'b1, 1'b0, 32'h10, 32'd0, 32'h1, 3'b010, 5'd0, 1'b0, -1, 0, 32'h0);
    chk("gto_err", err_cyc, 1);
    chk("gto_req_cycles", req_cyc, 4);
    chk("gto_hold_cycles", hold_cyc, 5);
    run_op(1'b0, 1'b1, 32'h20, 32'd0, 32'h0, 3'b010, 5'd3, 1'b1, 1, -1, 32'h0);
    chk("rto_err", err_cyc, 1);
    chk("rto_wbv", wbv_cyc, 0);
    run_op(1'b0, 1'b1, 32'h4000, 32'd2, 32'h0, 3'b010, 5'd4, 1'b1, 0, 1, 32'h11223344);
    chk("lw_mis_pulse", mis_cyc, TRAP ? 1 : 0);
    chk("lw_req_cycles", req_cyc, TRAP ? 0 : 1);
    run_op(1'b1, 1'b1, 32'h60, 32'd0, 32'h55, 3'b011, 5'd2, 1'b1, 0, 0, 32'h0);
    chk("both_we", c_we, 1'b1);
    chk("both_be", c_be, 4'b1111);
    chk("both_wbv", wbv_cyc, 0);
    run_op(1'b0, 1'b1, 32'h70, 32'd2, 32'h0, 3'b001, 5'd6, 1'b1, 1, 2, 32'h80011234);
    chk("lh_data", c_wbd, 32'hFFFF8001);
    run_op(1'b0, 1'b1, 32'h80, 32'd0, 32'h0, 3'b010, 5'd8, 1'b0, 0, 0, 32'hCAFEF00D);
    chk("nowen_wbv", wbv_cyc, 0);
    // Asynchronous reset while a load waits in RESP.
    op1 = 32'h50; op2 = '0; mem_size = 3'b010; mem_we = 1'b0; mem_re = 1'b1; reg_wen = 1'b1; rd_addr = 5'd7;
    e_hold = 1'b1; e_addr = 32'h50; e_be = 4'hF; e_we = 1'b0;
    @(posedge clk); #1 e_req = 1'b1; dm_gnt = 1'b1;
    @(posedge clk); #1 dm_gnt = 1'b0; e_req = 1'b0;
    @(negedge clk); #1;
    chk("resp_hold", hold, 1'b1);
    rst = 1'b0; mem_re = 1'b0; e_hold = 1'b0;
    #1;
    chk("arst_req", dm_req, 1'b0);
    chk("arst_hold", hold, 1'b0);
    @(posedge clk); #1 rst = 1'b1; wbv_cyc = 0; dm_rvalid = 1'b1; dm_rdata = 32'h12345678;
    @(posedge clk); #1 dm_rvalid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("late_rvalid_wbv", wbv_cyc, 0);
    run_op(1'b1, 1'b0, 32'h2000, 32'd1, 32'h0000005A, 3'b000, 5'd0, 1'b0, 0, 0, 32'h0);
    chk("post_rst_be", c_be, 4'b0010);
    chk("post_rst_wdata", c_wdata, 32'h5A5A5A5A);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
